// File: rtl/led_pwm_sequencer.sv
// Eight-channel LED brightness sequencer: ramps a shared level up, holds it at full
// scale, ramps it down, then advances to the next channel (chase) or repeats for all (unison).
module led_pwm_sequencer #(
  parameter int STEP_CYCLES = 97656,
  parameter int HOLD_STEPS  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  output logic [63:0] duty,
  output logic        duty_valid,
  output logic [2:0]  active_ch,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD    = 3'd2,
    DOWN    = 3'd3,
    ADVANCE = 3'd4
  } state_t;

  localparam logic [23:0] STEP_LAST = 24'(STEP_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_STEPS - 1);

  state_t      state;
  logic [7:0]  level;
  logic [23:0] step_cnt;
  logic [7:0]  hold_cnt;
  logic [2:0]  ch_ptr;
  logic        unison;
  logic        stop_pending;
  logic        tick;

  assign tick = (state != IDLE) && (step_cnt == STEP_LAST);

  function automatic logic [7:0] sat_inc(logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

  // Places the level in the active channel's byte, or in every byte for unison.
  function automatic logic [63:0] pack_duty(logic [7:0] lvl, logic [2:0] ch, logic all_ch);
    logic [63:0] d;
    d = '0;
    for (int c = 0; c < 8; c++) begin
      if (all_ch || (ch == 3'(c))) d[8*c +: 8] = lvl;
    end
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      level        <= '0;
      step_cnt     <= '0;
      hold_cnt     <= '0;
      ch_ptr       <= '0;
      unison       <= 1'b0;
      stop_pending <= 1'b0;
      duty         <= '0;
      duty_valid   <= 1'b0;
      active_ch    <= '0;
      busy         <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (state != IDLE) step_cnt <= tick ? '0 : step_cnt + 24'd1;

      case (state)
        IDLE: begin
          if (start) begin
            unison       <= mode;
            ch_ptr       <= '0;
            level        <= '0;
            step_cnt     <= '0;
            hold_cnt     <= '0;
            stop_pending <= 1'b0;
            active_ch    <= '0;
            busy         <= 1'b1;
            state        <= UP;
          end
        end

        UP: begin
          if (stop) stop_pending <= 1'b1;
          if (tick) begin
            level      <= sat_inc(level);
            duty       <= pack_duty(sat_inc(level), ch_ptr, unison);
            duty_valid <= 1'b1;
            if (level >= 8'd254) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
        end

        HOLD: begin
          if (stop) stop_pending <= 1'b1;
          if (tick) begin
            hold_cnt <= hold_cnt + 8'd1;
            if (hold_cnt == HOLD_LAST) state <= DOWN;
          end
        end

        DOWN: begin
          if (stop) stop_pending <= 1'b1;
          if (tick) begin
            level      <= sat_dec(level);
            duty       <= pack_duty(sat_dec(level), ch_ptr, unison);
            duty_valid <= 1'b1;
            if (level <= 8'd1) state <= ADVANCE;
          end
        end

        // A stop seen here only arms the next ADVANCE; the decision uses the earlier request.
        ADVANCE: begin
          if (stop_pending) begin
            stop_pending <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            stop_pending <= stop;
            if (!unison) begin
              ch_ptr    <= ch_ptr + 3'd1;
              active_ch <= ch_ptr + 3'd1;
            end
            state <= UP;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Scoreboard bench for led_pwm_sequencer with STEP_CYCLES=4, HOLD_STEPS=2:
// expected strobes (cycle, duty, channel) are queued by the stimulus and popped by a monitor.
module tb_led_pwm_sequencer;

  localparam int SC     = 4;
  localparam int HS     = 2;
  localparam int CH_CYC = 2048;  // cycles from one channel's start to the next

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [63:0] duty;
  logic        duty_valid;
  logic [2:0]  active_ch;
  logic        busy;

  led_pwm_sequencer #(.STEP_CYCLES(SC), .HOLD_STEPS(HS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .duty(duty), .duty_valid(duty_valid), .active_ch(active_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] duty;
    logic [2:0]  ch;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  logic        rst_q = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          chk_uni = 1'b0;
  logic [63:0] prev_duty = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endfunction

  function automatic logic [63:0] exp_duty(int lvl, int ch, bit uni);
    logic [63:0] d;
    d = '0;
    for (int c = 0; c < 8; c++) if (uni || c == ch) d[8*c +: 8] = 8'(lvl);
    return d;
  endfunction

  // Channel n of a run started at edge s: ramp tick k lands on edge s+2048n+4k.
  task automatic push_chan(int s, int n, bit uni, int kmax, bit full);
    exp_t e;
    for (int k = 1; k <= kmax; k++) begin
      e.cyc  = s + CH_CYC * n + 4 * k;
      e.duty = exp_duty(k, n % 8, uni);
      e.ch   = uni ? 3'd0 : 3'(n % 8);
      q.push_back(e);
    end
    if (full) begin
      for (int k = 258; k <= 512; k++) begin
        e.cyc  = s + CH_CYC * n + 4 * k;
        e.duty = exp_duty(512 - k, n % 8, uni);
        e.ch   = uni ? 3'd0 : 3'(n % 8);
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  exp_t e_mon;
  int   nz;
  bit   all_eq;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) check("strobe_iff_change", 64'(duty_valid), 64'(duty != prev_duty));
      nz = 0;
      all_eq = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (duty[8*c +: 8] != 8'h00) nz++;
        if (duty[8*c +: 8] != duty[7:0]) all_eq = 1'b0;
      end
      if (chk_uni) begin
        check("unison_bytes_equal", 64'(all_eq), 64'd1);
        check("unison_active_ch", 64'(active_ch), 64'd0);
      end else begin
        check("chase_one_byte", 64'(nz <= 1), 64'd1);
      end
      if (duty_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe: got duty %h with nothing expected at cycle %0d", duty, cyc);
        end else begin
          e_mon = q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(e_mon.cyc));
          check("strobe_duty", duty, e_mon.duty);
          check("strobe_ch", 64'(active_ch), 64'(e_mon.ch));
        end
      end
      prev_duty = duty;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int s;

  initial begin
    wait_cyc(3);
    check("rst_duty", duty, 64'h0);
    check("rst_duty_valid", 64'(duty_valid), 64'd0);
    check("rst_active_ch", 64'(active_ch), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    prev_duty = duty;
    mon_en = 1'b1;
    rst_n = 1'b1;

    // Chase through all eight channels, wrap to channel 0, reset during its HOLD.
    chk_uni = 1'b0;
    s = cyc + 1;
    for (int n = 0; n < 8; n++) push_chan(s, n, 1'b0, 255, 1'b1);
    push_chan(s, 8, 1'b0, 255, 1'b0);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b1;
    check("busy_after_start", 64'(busy), 64'd1);
    wait_cyc(s + CH_CYC + 1);
    check("advance_to_ch1", 64'(active_ch), 64'd1);
    check("busy_after_advance", 64'(busy), 64'd1);
    wait_cyc(s + 8 * CH_CYC + 1);
    check("wrap_to_ch0", 64'(active_ch), 64'd0);
    wait_cyc(s + 8 * CH_CYC + 1021);
    check("hold_full_scale", duty, exp_duty(255, 0, 1'b0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 1'b0;
    check("midrst_duty", duty, 64'h0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_duty_valid", 64'(duty_valid), 64'd0);
    check("midrst_active_ch", 64'(active_ch), 64'd0);
    check("queue_empty_chase", 64'(q.size()), 64'd0);

    // Unison with start/stop collision; stop raised during ADVANCE ends after the next ramp.
    chk_uni = 1'b1;
    @(negedge clk);
    s = cyc + 1;
    push_chan(s, 0, 1'b1, 255, 1'b1);
    push_chan(s, 1, 1'b1, 255, 1'b1);
    start = 1'b1;
    stop  = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    check("collision_busy", 64'(busy), 64'd1);
    wait_cyc(s + CH_CYC);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_in_advance_deferred", 64'(busy), 64'd1);
    wait_cyc(s + 2 * CH_CYC);
    check("unison_busy_last_advance", 64'(busy), 64'd1);
    @(negedge clk);
    check("unison_stopped_busy", 64'(busy), 64'd0);
    check("unison_stopped_duty", duty, 64'h0);
    check("queue_empty_unison", 64'(q.size()), 64'd0);
    chk_uni = 1'b0;

    // Chase, stop mid-ramp on channel 3 (start/mode pulses there must be ignored).
    @(negedge clk);
    s = cyc + 1;
    for (int n = 0; n < 4; n++) push_chan(s, n, 1'b0, 255, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(s + 3 * CH_CYC + 499);
    stop  = 1'b1;
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    wait_cyc(s + 4 * CH_CYC);
    check("stop_busy_in_advance", 64'(busy), 64'd1);
    @(negedge clk);
    check("stop_busy_cleared", 64'(busy), 64'd0);
    check("stop_duty_zero", duty, 64'h0);
    check("queue_empty_stop", 64'(q.size()), 64'd0);

    // Restart after stop, then reset shortly after the third step.
    s = cyc + 1;
    push_chan(s, 0, 1'b0, 3, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 64'(busy), 64'd1);
    wait_cyc(s + 13);
    check("restart_level3", duty, 64'h03);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("restart_rst_busy", 64'(busy), 64'd0);
    check("restart_rst_duty", duty, 64'h0);
    check("queue_empty_restart", 64'(q.size()), 64'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
